// File: rtl/window_fetch_ctrl_if.sv
// Handshake bundle around window_fetch_ctrl: address counter requests/strobes,
// pixel memory bus, edge-filter window/result exchange and frame status.
interface window_fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int PIX_W  = 8
);
    // frame control
    logic                 i_start;
    logic                 i_stop;
    logic                 o_busy;
    logic                 o_frame_done;

    // address counter
    logic                 o_inc_raddr;
    logic                 i_r_ready;
    logic [ADDR_W-1:0]    i_raddr;
    logic                 o_inc_waddr;
    logic                 i_w_ready;
    logic [ADDR_W-1:0]    i_waddr;
    logic                 i_done;

    // pixel memory
    logic                 o_mem_read;
    logic                 o_mem_write;
    logic [ADDR_W-1:0]    o_mem_addr;
    logic [PIX_W-1:0]     o_mem_wdata;
    logic [PIX_W-1:0]     i_mem_rdata;
    logic                 i_mem_ack;

    // edge filter
    logic                 o_win_valid;
    logic [9*PIX_W-1:0]   o_win_data;
    logic                 i_res_valid;
    logic [PIX_W-1:0]     i_res_data;

    // The fetch controller drives the o_* side.
    modport master (
        input  i_start, i_stop, i_r_ready, i_raddr, i_w_ready, i_waddr, i_done,
               i_mem_rdata, i_mem_ack, i_res_valid, i_res_data,
        output o_busy, o_frame_done, o_inc_raddr, o_inc_waddr, o_mem_read,
               o_mem_write, o_mem_addr, o_mem_wdata, o_win_valid, o_win_data
    );

    // Counter, memory and filter together form the opposite side.
    modport slave (
        output i_start, i_stop, i_r_ready, i_raddr, i_w_ready, i_waddr, i_done,
               i_mem_rdata, i_mem_ack, i_res_valid, i_res_data,
        input  o_busy, o_frame_done, o_inc_raddr, o_inc_waddr, o_mem_read,
               o_mem_write, o_mem_addr, o_mem_wdata, o_win_valid, o_win_data
    );
endinterface

// File: rtl/window_fetch_ctrl.sv
// Window fetch controller: walks the address counter, reads 9 pixels into a
// 3x3 window, hands it to the edge filter and writes the result back, one
// window per write address until the counter flags the last one.
module window_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int PIX_W  = 8
) (
    input logic                 clk,
    input logic                 rst,
    window_fetch_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_RD_MEM, S_WIN_OUT,
        S_WR_REQ, S_WR_WAIT, S_WR_MEM, S_DONE
    } state_t;

    state_t             r_state,      w_state_nxt;
    logic [3:0]         r_count,      w_count_nxt;
    logic               r_first_rd,   w_first_rd_nxt;
    logic               r_first_wr,   w_first_wr_nxt;
    logic               r_last,       w_last_nxt;
    logic               r_inc_raddr,  w_inc_raddr_nxt;
    logic               r_inc_waddr,  w_inc_waddr_nxt;
    logic               r_mem_read,   w_mem_read_nxt;
    logic               r_mem_write,  w_mem_write_nxt;
    logic [ADDR_W-1:0]  r_mem_addr,   w_mem_addr_nxt;
    logic [PIX_W-1:0]   r_mem_wdata,  w_mem_wdata_nxt;
    logic               r_win_valid,  w_win_valid_nxt;
    logic [9*PIX_W-1:0] r_win_data,   w_win_data_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic               r_busy;

    // Next state and next value of every registered output.
    always_comb begin
        // NOTE: every target gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_first_rd_nxt   = r_first_rd;
        w_first_wr_nxt   = r_first_wr;
        w_last_nxt       = r_last;
        w_mem_read_nxt   = r_mem_read;
        w_mem_write_nxt  = r_mem_write;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_win_valid_nxt  = r_win_valid;
        w_win_data_nxt   = r_win_data;
        w_inc_raddr_nxt  = 1'b0;
        w_inc_waddr_nxt  = 1'b0;
        w_frame_done_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_first_rd_nxt = 1'b1;
                    w_first_wr_nxt = 1'b1;
                    w_state_nxt    = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                // The counter already presents the frame's first address.
                if (r_first_rd) begin
                    w_mem_addr_nxt = bus.i_raddr;
                    w_first_rd_nxt = 1'b0;
                    w_mem_read_nxt = 1'b1;
                    w_state_nxt    = S_RD_MEM;
                end else begin
                    w_inc_raddr_nxt = 1'b1;
                    w_state_nxt     = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bus.i_r_ready) begin
                    w_mem_addr_nxt = bus.i_raddr;
                    w_mem_read_nxt = 1'b1;
                    w_state_nxt    = S_RD_MEM;
                end
            end
            S_RD_MEM: begin
                if (bus.i_mem_ack) begin
                    w_win_data_nxt[PIX_W*r_count +: PIX_W] = bus.i_mem_rdata;
                    w_mem_read_nxt = 1'b0;
                    if (r_count == 4'd8) begin
                        w_count_nxt     = 4'd0;
                        w_win_valid_nxt = 1'b1;
                        w_state_nxt     = S_WIN_OUT;
                    end else begin
                        w_count_nxt = r_count + 4'd1;
                        w_state_nxt = S_RD_REQ;
                    end
                end
            end
            S_WIN_OUT: begin
                if (bus.i_res_valid) begin
                    w_mem_wdata_nxt = bus.i_res_data;
                    w_win_valid_nxt = 1'b0;
                    w_state_nxt     = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                // The first write address of a frame is never the last one.
                if (r_first_wr) begin
                    w_mem_addr_nxt  = bus.i_waddr;
                    w_first_wr_nxt  = 1'b0;
                    w_last_nxt      = 1'b0;
                    w_mem_write_nxt = 1'b1;
                    w_state_nxt     = S_WR_MEM;
                end else begin
                    w_inc_waddr_nxt = 1'b1;
                    w_state_nxt     = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (bus.i_w_ready) begin
                    w_mem_addr_nxt  = bus.i_waddr;
                    w_last_nxt      = bus.i_done;
                    w_mem_write_nxt = 1'b1;
                    w_state_nxt     = S_WR_MEM;
                end
            end
            S_WR_MEM: begin
                if (bus.i_mem_ack) begin
                    w_mem_write_nxt = 1'b0;
                    if (r_last) begin
                        w_frame_done_nxt = 1'b1;
                        w_state_nxt      = S_DONE;
                    end else begin
                        w_state_nxt = S_RD_REQ;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort wins over everything, including a same-cycle start; the
        // in-flight memory request is simply withdrawn.
        if (bus.i_stop) begin
            w_state_nxt      = S_IDLE;
            w_count_nxt      = 4'd0;
            w_last_nxt       = 1'b0;
            w_inc_raddr_nxt  = 1'b0;
            w_inc_waddr_nxt  = 1'b0;
            w_mem_read_nxt   = 1'b0;
            w_mem_write_nxt  = 1'b0;
            w_win_valid_nxt  = 1'b0;
            w_frame_done_nxt = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_count      <= 4'd0;
            r_first_rd   <= 1'b1;
            r_first_wr   <= 1'b1;
            r_last       <= 1'b0;
            r_inc_raddr  <= 1'b0;
            r_inc_waddr  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_win_valid  <= 1'b0;
            // NOTE: the nine pixel slots are plain flops, so they clear with the rest; a RAM-based store could not be reset this way.
            r_win_data   <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_first_rd   <= w_first_rd_nxt;
            r_first_wr   <= w_first_wr_nxt;
            r_last       <= w_last_nxt;
            r_inc_raddr  <= w_inc_raddr_nxt;
            r_inc_waddr  <= w_inc_waddr_nxt;
            r_mem_read   <= w_mem_read_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_win_valid  <= w_win_valid_nxt;
            r_win_data   <= w_win_data_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.o_inc_raddr  = r_inc_raddr;
    assign bus.o_inc_waddr  = r_inc_waddr;
    assign bus.o_mem_read   = r_mem_read;
    assign bus.o_mem_write  = r_mem_write;
    assign bus.o_mem_addr   = r_mem_addr;
    assign bus.o_mem_wdata  = r_mem_wdata;
    assign bus.o_win_valid  = r_win_valid;
    assign bus.o_win_data   = r_win_data;
    assign bus.o_busy       = r_busy;
    assign bus.o_frame_done = r_frame_done;

endmodule

// File: doc/window_fetch_ctrl.md
Name: window_fetch_ctrl

Overview:
- Initiator/consumer for the address counter: requests read/write addresses via increment pulses, waits for ready, and runs the matching memory transactions.
- Assembles 9 read pixels into a 3x3 window and hands it to the edge filter.
- Writes the filter result to the write address; repeats until the counter flags the last write address.

Parameters:
ADDR_W, 32, memory address width (matches address counter outputs)
PIX_W, 8, pixel and result width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
i_start  in  1  begin frame (pulse); honoured only in IDLE
i_stop  in  1  abort; priority over all other inputs
o_inc_raddr  out  1  one-cycle request for next read address
i_r_ready  in  1  read address valid strobe (one cycle)
i_raddr  in  ADDR_W  current read address
o_inc_waddr  out  1  one-cycle request for next write address
i_w_ready  in  1  write address valid strobe (one cycle)
i_waddr  in  ADDR_W  current write address
i_done  in  1  last write address flag, qualified by i_w_ready
o_mem_read  out  1  memory read request, held until ack
o_mem_write  out  1  memory write request, held until ack
o_mem_addr  out  ADDR_W  memory address, registered
o_mem_wdata  out  PIX_W  write data
i_mem_rdata  in  PIX_W  read data, valid with ack
i_mem_ack  in  1  one-cycle transaction acknowledge
o_win_valid  out  1  window valid to filter, held until result
o_win_data  out  9*PIX_W  pixel k at bits [PIX_W*k +: PIX_W]; k=0 is first fetched
i_res_valid  in  1  filter result strobe
i_res_data  in  PIX_W  filter result
o_busy  out  1  high in any state except IDLE
o_frame_done  out  1  one-cycle pulse after last write is acked

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Pixel count 0. first_rd=1, first_wr=1, last=0.
- All outputs are registered.
- IDLE:
  - i_start -> RD_REQ.
  - Set first_rd=1 and first_wr=1.
- RD_REQ:
  - If first_rd: latch i_raddr into o_mem_addr, clear first_rd, go to RD_MEM. No inc pulse: the counter already presents the initial address.
  - Else: assert o_inc_raddr for exactly one cycle, go to RD_WAIT.
- RD_WAIT:
  - On i_r_ready: o_mem_addr <= i_raddr, go to RD_MEM.
  - No timeout.
- RD_MEM:
  - o_mem_read=1 until the cycle i_mem_ack is seen.
  - On ack: slot[count] <= i_mem_rdata, count++, o_mem_read drops next cycle.
  - If count was 8: count <= 0, go to WIN_OUT. Else go to RD_REQ.
- Read latency: minimum 3 cycles per non-first pixel, excluding counter and memory latency.
- WIN_OUT:
  - o_win_valid=1, o_win_data stable.
  - On i_res_valid: capture i_res_data into o_mem_wdata, drop o_win_valid, go to WR_REQ.
- WR_REQ / WR_WAIT: same as RD_REQ / RD_WAIT but using o_inc_waddr, i_w_ready, i_waddr and first_wr. On i_w_ready, last <= i_done.
  - first_wr path: no inc pulse, and last is forced to 0. The first write address is never the last.
- WR_MEM:
  - o_mem_write=1 until i_mem_ack.
  - On ack with last=1: go to DONE. Otherwise go to RD_REQ; every window is refetched in full, 9 pixels.
- DONE: o_frame_done=1 for one cycle, then IDLE.
- Mutual exclusion: o_mem_read and o_mem_write are never high together. o_inc_raddr and o_inc_waddr are never high together.
- Ignored inputs:
  - i_r_ready / i_w_ready outside their WAIT state.
  - i_mem_ack outside RD_MEM / WR_MEM.
  - i_res_valid outside WIN_OUT.
  - i_start outside IDLE.
- i_stop (any state):
  - Next cycle: IDLE, all request/valid outputs 0, count=0, last=0.
  - An in-flight memory request is dropped; memory must tolerate the withdrawal.
  - o_frame_done is not pulsed.
  - Same-cycle i_start is ignored.
- Reset mid-operation: same as i_stop, but asynchronous. o_mem_addr, o_mem_wdata and o_win_data are also cleared to 0.

Test Plan:
- Reset, then i_start with i_raddr=0x1000 held, memory acks 1 cycle after request returning data = low byte of address:
  - first read at 0x1000 with no o_inc_raddr pulse;
  - the next 8 reads each preceded by exactly one inc pulse;
  - o_win_valid with slot0=0x00.
- Window ready, filter returns i_res_valid with 0xA5 after 4 cycles:
  - o_win_valid drops next cycle;
  - o_mem_write to i_waddr=0x2000 with wdata 0xA5, no o_inc_waddr on the first write.
- Second window:
  - exactly 9 o_inc_raddr pulses, then one o_inc_waddr pulse;
  - o_mem_addr equals i_raddr/i_waddr sampled at the ready strobes.
- i_done=1 with i_w_ready on the 2nd write -> after that write's ack, o_frame_done pulses once, then o_busy=0.
- i_stop asserted while o_mem_read=1 during pixel 5 -> next cycle IDLE, o_mem_read=0, o_busy=0; a late i_mem_ack is ignored and no state change.
- Spurious i_r_ready, i_mem_ack and i_res_valid in IDLE and WIN_OUT -> no output change except as specified (i_res_valid accepted only in WIN_OUT).
